// File: rtl/csr_fwd_tracker.sv
// CSR write tracker: follows in-flight CSR writers through the stages after ID,
// picks the youngest matching writer for forwarding and stalls when it is not ready.
`ifndef CSR_IR
`define CSR_IR 4'd5
`endif

module csr_fwd_tracker #(
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 2,
  parameter int READY_STAGE = 0,
  parameter int SEL_W       = $clog2(DEPTH+1),
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] csr_addr_in_id,
  input  logic [3:0]        ir_type_in_id,
  input  logic              wr_csr_n_in_id,
  input  logic              hold,
  input  logic [DEPTH-1:0]  flush,
  output logic [SEL_W-1:0]  forward_z,
  output logic [DEPTH-1:0]  forward_sel,
  output logic              csr_stall,
  output logic [CNT_W-1:0]  stall_cycles
);

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;
  logic [DEPTH-1:0]  match;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [SEL_W-1:0]  idx;
  logic              is_csr;
  logic              hit;
  logic              cap;

  assign is_csr = (ir_type_in_id == `CSR_IR);

  // Lowest index wins: scanning downward leaves the youngest match last.
  always_comb begin
    match       = '0;
    hit         = 1'b0;
    idx         = '0;
    forward_z   = '0;
    forward_sel = '0;
    csr_stall   = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      match[k] = valid_q[k] && (addr_q[k] == csr_addr_in_id) && is_csr;
    end
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (match[k]) begin
        hit = 1'b1;
        idx = SEL_W'(k);
      end
    end
    if (hit) begin
      if (int'(idx) >= READY_STAGE) begin
        forward_z        = idx + 1'b1;
        forward_sel[idx] = 1'b1;
      end else begin
        csr_stall = 1'b1;
      end
    end
  end

  assign cap = is_csr && !wr_csr_n_in_id && !csr_stall;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (!hold) begin
      valid_d[0] = cap;
      addr_d[0]  = csr_addr_in_id;
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        addr_d[k]  = addr_q[k-1];
      end
    end
    valid_d = valid_d & ~flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      stall_cycles <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      if (csr_stall && !hold && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

endmodule

// File: doc/csr_fwd_tracker.md
# csr_fwd_tracker

Parametrised CSR write tracker and forwarding/hazard unit for the rv32i pipeline. It records every in-flight CSR write in a DEPTH-entry shift pipeline that mirrors the stages after ID. For the CSR instruction currently in ID it selects the youngest in-flight writer of the same CSR for forwarding. When that writer's value is not yet available, it raises a stall and inserts a bubble. It also counts stall cycles for performance monitoring.

## Interface
Parameters:
- ADDR_W, 12, CSR address width
- DEPTH, 2, number of tracked stages after ID; entry 0 = EX, entry 1 = MEM, and so on (DEPTH ≥ 1)
- READY_STAGE, 0, lowest entry index whose write value can be forwarded (0 ≤ READY_STAGE < DEPTH)
- SEL_W, $clog2(DEPTH+1), forward_z width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- csr_addr_in_id  in  ADDR_W  CSR address of the ID instruction
- ir_type_in_id  in  4  ID instruction type; compared with `CSR_IR` from constants/ir_type.v
- wr_csr_n_in_id  in  1  active-low; ID instruction writes its CSR
- hold  in  1  whole pipeline frozen this cycle
- flush  in  DEPTH  bit k clears entry k at the next edge
- forward_z  out  SEL_W  0 = no forward; k = forward from entry k-1
- forward_sel  out  DEPTH  one-hot form of forward_z; all zero if none
- csr_stall  out  1  ID must stall; a bubble enters EX
- stall_cycles  out  CNT_W  saturating count of stall cycles

## Operation
- Each entry k holds {valid, addr}.
- Match rule: match[k] = valid[k] && addr[k] == csr_addr_in_id && ir_type_in_id == `CSR_IR`.
- Youngest match j is the lowest k with match[k]. Priority is strictly by index, so duplicate writers never cause ambiguity.
- If j exists and j ≥ READY_STAGE: forward_z = j+1, forward_sel[j] = 1, csr_stall = 0.
- If j exists and j < READY_STAGE: csr_stall = 1, forward_z = 0, forward_sel = 0.
- Older matches are ignored when a younger match exists, even if the younger one is not ready. The unit stalls rather than forward stale data.
- With DEPTH=2 and READY_STAGE=0 the encoding is 01 = EX and 10 = MEM, identical to the existing 2-bit forward_z.
- Capture: cap = (ir_type_in_id == `CSR_IR`) && !wr_csr_n_in_id && !csr_stall.
- Clock edge, hold = 0:
  - entry[k] ← entry[k-1] for k ≥ 1
  - entry[0] ← {cap, csr_addr_in_id}
  - entry[DEPTH-1] is discarded
  - afterwards, valid[k] ← 0 for every set flush[k] (flush applies to the new positions)
- Clock edge, hold = 1: no shift; flush[k] still clears entry k in place.
- Stalled ID instruction: it never enters the tracker. A bubble (valid = 0) enters entry 0 and the writer advances until it reaches READY_STAGE.
- stall_cycles: +1 on each edge with csr_stall = 1 && hold = 0. It saturates at all-ones and is cleared only by reset.
- All outputs except stall_cycles are combinational from the current state and the ID inputs. There are no registered outputs besides the entries and the counter.

## Timing
- Reset (rst_n = 0, asynchronous): all valid = 0 and stall_cycles = 0, so forward_z = 0, forward_sel = 0 and csr_stall = 0 immediately.
- Reset deassertion takes effect at the first rising edge with rst_n = 1.
- Reset mid-stall clears the pending writer. csr_stall drops in the same cycle reset asserts; no residual stall remains after release.
- Write-to-read latency (READY_STAGE = 0): writer in ID at cycle t, reader in ID at t+1 gives forward_z = 1 at t+1. Reader at t+2 gives forward_z = 2.
- Stall length: a reader immediately behind a writer stalls for exactly READY_STAGE unheld cycles.
- Cycles with hold = 1 extend the stall but are not counted in stall_cycles.
- Flush and stall in the same cycle: flush[j] kills the writer, so csr_stall = 0 on the following cycle (unless another match exists).
- An entry is lost after DEPTH unheld edges. No match is possible past the last stage.

## Test plan
- Reset: assert rst_n = 0 mid-run with entries valid → forward_z = 0, csr_stall = 0, stall_cycles = 0 without a clock edge.
- DEPTH=2, READY_STAGE=0:
  - write 0x300, then read 0x300 next cycle → forward_z = 1
  - with one bubble between → forward_z = 2
  - writes to 0x300 at t and t+1, read at t+2 → forward_z = 1 (youngest wins)
- DEPTH=3, READY_STAGE=1: write 0x305 at t, read 0x305 at t+1 → csr_stall = 1 at t+1. At t+2 → csr_stall = 0, forward_z = 2, stall_cycles = 1.
- Same as above, but hold = 1 for cycles t+1..t+3 → csr_stall stays 1 through t+3, stall_cycles = 0 until the first unheld edge, then resolves as above.
- Write 0x341 at t, flush[0] = 1 at the t edge, read 0x341 at t+1 → forward_z = 0. Repeat with flush[1] one cycle later at DEPTH=2 → forward_z drops from 2 to 0 at t+2.
- No-capture cases, each followed by a read to the same address giving forward_z = 0:
  - address mismatch (0x300 vs 0x301)
  - ir_type ≠ `CSR_IR`
  - wr_csr_n_in_id = 1
- Counter saturation: with CNT_W = 2, four stall cycles → stall_cycles = 3.
